// File: rtl/gray_count_decoder.sv
// Receive-side Gray count decoder: converts a sampled Gray count to binary,
// classifies each transition as up/down step, wrap or code error.
module gray_count_decoder #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [N-1:0]  gray_in,
   input  logic          clr_err,
   output logic [N-1:0]  bin_out,
   output logic          bin_valid,
   output logic          step_up,
   output logic          step_dn,
   output logic          wrap,
   output logic          err,
   output logic          err_sticky,
   output logic [CW-1:0] err_count,
   output logic          dbg_state
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0]  ALL1_N  = {N{1'b1}};
   localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t        state_q, state_d;
   logic [N-1:0]  prev_gray_q, prev_gray_d;
   logic [N-1:0]  bin_q, bin_d;
   logic          valid_q, valid_d;
   logic          step_up_q, step_up_d;
   logic          step_dn_q, step_dn_d;
   logic          wrap_q, wrap_d;
   logic          err_q, err_d;
   logic          sticky_q, sticky_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  diff;
   logic [N-1:0]  new_bin;
   logic          diff_zero;
   logic          diff_one;

   // A single set bit in diff means a legal one-bit Gray transition.
   assign diff      = gray_in ^ prev_gray_q;
   assign new_bin   = gray2bin(gray_in);
   assign diff_zero = (diff == '0);
   assign diff_one  = !diff_zero && ((diff & (diff - ONE_N)) == '0);

   always_comb begin
      state_d     = state_q;
      prev_gray_d = prev_gray_q;
      bin_d       = bin_q;
      valid_d     = valid_q;
      step_up_d   = 1'b0;
      step_dn_d   = 1'b0;
      wrap_d      = 1'b0;
      err_d       = 1'b0;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;

      // Clear first so a same-edge error lands on a zeroed counter.
      if (clr_err) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end

      if (enable) begin
         case (state_q)
            ST_EMPTY: begin
               prev_gray_d = gray_in;
               bin_d       = new_bin;
               valid_d     = 1'b1;
               state_d     = ST_TRACK;
            end
            ST_TRACK: begin
               if (!diff_zero) begin
                  prev_gray_d = gray_in;
                  bin_d       = new_bin;
                  if (diff_one) begin
                     if (new_bin == bin_q + ONE_N) begin
                        step_up_d = 1'b1;
                        wrap_d    = (bin_q == ALL1_N);
                     end else if (new_bin == bin_q - ONE_N) begin
                        step_dn_d = 1'b1;
                        wrap_d    = (bin_q == '0);
                     end
                  end else begin
                     err_d    = 1'b1;
                     sticky_d = 1'b1;
                     if (cnt_d != CNT_MAX) begin
                        cnt_d = cnt_d + ONE_C;
                     end
                  end
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         prev_gray_q <= '0;
         bin_q       <= '0;
         valid_q     <= 1'b0;
         step_up_q   <= 1'b0;
         step_dn_q   <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_gray_q <= prev_gray_d;
         bin_q       <= bin_d;
         valid_q     <= valid_d;
         step_up_q   <= step_up_d;
         step_dn_q   <= step_dn_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bin_out    = bin_q;
   assign bin_valid  = valid_q;
   assign step_up    = step_up_q;
   assign step_dn    = step_dn_q;
   assign wrap       = wrap_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;
   assign err_count  = cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_gray_count_decoder.sv
// Directed bench for gray_count_decoder (N=4, CW=2): expected outputs are
// queued per driven cycle and popped by an independent monitor.
module tb_gray_count_decoder;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] gray_in;
   logic       clr_err;
   logic [3:0] bin_out;
   logic       bin_valid;
   logic       step_up;
   logic       step_dn;
   logic       wrap;
   logic       err;
   logic       err_sticky;
   logic [1:0] err_count;
   logic       dbg_state;

   gray_count_decoder #(.N(4), .CW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .gray_in    (gray_in),
      .clr_err    (clr_err),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .step_up    (step_up),
      .step_dn    (step_dn),
      .wrap       (wrap),
      .err        (err),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {bin_valid, bin_out, step_up, step_dn, wrap, err, err_sticky, err_count}
   logic [11:0] act;
   assign act = {bin_valid, bin_out, step_up, step_dn, wrap, err, err_sticky, err_count};

   logic [11:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_item   = 0;

   function automatic logic [11:0] ev(input logic v, input logic [3:0] b,
                                      input logic u, input logic d, input logic w,
                                      input logic er, input logic st, input logic [1:0] c);
      return {v, b, u, d, w, er, st, c};
   endfunction

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         n_checks++;
         n_item++;
         if (act === e) n_pass++;
         else $display("FAIL item_%0d: got %b required %b (v,bin,up,dn,wrap,err,sticky,cnt)",
                       n_item, act, e);
      end
   end

   task automatic drive(input logic en, input logic [3:0] g, input logic clr,
                        input logic [11:0] e);
      @(negedge clk);
      enable  = en;
      gray_in = g;
      clr_err = clr;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int budget;
      @(negedge clk);
      enable  = 1'b0;
      clr_err = 1'b0;
      budget  = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic reset_check(input string name);
      drain();
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (act === 12'h000) n_pass++;
      else $display("FAIL %s: got %b required %b", name, act, 12'h000);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset   = 1'b0;
      enable  = 1'b0;
      gray_in = 4'b0000;
      clr_err = 1'b0;
      #12;
      n_checks++;
      if (act === 12'h000) n_pass++;
      else $display("FAIL reset_state: got %b required %b", act, 12'h000);
      @(negedge clk);
      reset = 1'b1;

      // Disabled sampling leaves the block empty.
      drive(1'b0, 4'b0101, 1'b0, ev(0, 4'd0, 0, 0, 0, 0, 0, 2'd0));
      // Up-count 0..4.
      drive(1'b1, 4'b0000, 1'b0, ev(1, 4'd0, 0, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0001, 1'b0, ev(1, 4'd1, 1, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0011, 1'b0, ev(1, 4'd2, 1, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 1, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0110, 1'b0, ev(1, 4'd4, 1, 0, 0, 0, 0, 2'd0));

      // Mid-count async reset, then first sample takes the empty path.
      reset_check("reset_mid_count");
      drive(1'b1, 4'b0110, 1'b0, ev(1, 4'd4, 0, 0, 0, 0, 0, 2'd0));

      // Wrap up and down through 15 <-> 0.
      reset_check("reset_before_wrap");
      drive(1'b1, 4'b1001, 1'b0, ev(1, 4'd14, 0, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b1000, 1'b0, ev(1, 4'd15, 1, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0000, 1'b0, ev(1, 4'd0,  1, 0, 1, 0, 0, 2'd0));
      drive(1'b1, 4'b1000, 1'b0, ev(1, 4'd15, 0, 1, 1, 0, 0, 2'd0));
      drive(1'b1, 4'b0000, 1'b0, ev(1, 4'd0,  1, 0, 1, 0, 0, 2'd0));

      // Two-bit jump is an error; tracking resumes from the new value.
      drive(1'b1, 4'b0011, 1'b0, ev(1, 4'd2, 0, 0, 0, 1, 1, 2'd1));
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 1, 0, 0, 0, 1, 2'd1));

      // Clear alone, then saturation of the 2-bit counter.
      drive(1'b0, 4'b0010, 1'b1, ev(1, 4'd3, 0, 0, 0, 0, 0, 2'd0));
      drive(1'b1, 4'b0001, 1'b0, ev(1, 4'd1, 0, 0, 0, 1, 1, 2'd1));
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 0, 0, 0, 1, 1, 2'd2));
      drive(1'b1, 4'b0001, 1'b0, ev(1, 4'd1, 0, 0, 0, 1, 1, 2'd3));
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 0, 0, 0, 1, 1, 2'd3));
      drive(1'b1, 4'b0001, 1'b0, ev(1, 4'd1, 0, 0, 0, 1, 1, 2'd3));
      drive(1'b0, 4'b0001, 1'b1, ev(1, 4'd1, 0, 0, 0, 0, 0, 2'd0));
      // Clear together with an error: clear first, then count it.
      drive(1'b1, 4'b0010, 1'b1, ev(1, 4'd3, 0, 0, 0, 1, 1, 2'd1));

      // Repeated value and disabled cycles hold everything.
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 0, 0, 0, 0, 1, 2'd1));
      drive(1'b1, 4'b0010, 1'b0, ev(1, 4'd3, 0, 0, 0, 0, 1, 2'd1));
      drive(1'b0, 4'b0110, 1'b0, ev(1, 4'd3, 0, 0, 0, 0, 1, 2'd1));
      drive(1'b0, 4'b1111, 1'b0, ev(1, 4'd3, 0, 0, 0, 0, 1, 2'd1));
      drive(1'b1, 4'b0110, 1'b0, ev(1, 4'd4, 1, 0, 0, 0, 1, 2'd1));

      reset_check("reset_after_errors");
      drive(1'b1, 4'b0110, 1'b0, ev(1, 4'd4, 0, 0, 0, 0, 0, 2'd0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Receive-side companion of gray_counter. Samples an N-bit Gray-coded count and converts it to binary.
- Checks every transition against the single-bit-change rule and reports up/down steps, wrap-around and code errors.
- Sits at the consumer end of any Gray-coded counter path, for example pointer or position monitoring, all in the counter's clock domain.

Parameters:
- N, 4, width of the Gray input and the binary output (N >= 2).
- CW, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Low clears all state.
- enable  input  1  sample qualifier. gray_in is sampled only on edges where enable=1.
- gray_in  input  N  Gray-coded count from the transmitting counter.
- clr_err  input  1  synchronous clear of err_count and err_sticky.
- bin_out  output  N  binary value of the last accepted sample.
- bin_valid  output  1  high once the first sample has been accepted.
- step_up  output  1  one-cycle pulse: the sample is the previous value +1 mod 2^N.
- step_dn  output  1  one-cycle pulse: the sample is the previous value -1 mod 2^N.
- wrap  output  1  one-cycle pulse: the step crossed 2^N-1 <-> 0 in either direction.
- err  output  1  one-cycle pulse: the sample differs from the previous Gray value in more than 1 bit.
- err_sticky  output  1  set by any err pulse, held until clr_err or reset.
- err_count  output  CW  number of err pulses, saturating at 2^CW-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: bin_out=0, bin_valid=0, all pulses 0, err_sticky=0, err_count=0.
  - Internal state: prev_gray=0, FSM to EMPTY.
- Gray-to-binary conversion: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i]. Combinational on gray_in, result registered.
- Latency: all outputs update on the same rising edge that samples gray_in. Results are visible 1 cycle after enable=1 is presented.
- FSM has 2 states:
  - EMPTY: no reference sample held.
  - TRACK: prev_gray/bin_out hold a valid reference.
- EMPTY & enable=1:
  - Load prev_gray=gray_in and bin_out=conv(gray_in); set bin_valid=1; go to TRACK.
  - No step/wrap/err checking on this first sample.
- TRACK & enable=1: compute d = popcount(gray_in ^ prev_gray).
  - d=0: hold. No pulses; bin_out unchanged.
  - d=1, new bin = bin_out+1 mod 2^N: step_up=1. wrap=1 if bin_out=2^N-1.
  - d=1, new bin = bin_out-1 mod 2^N: step_dn=1. wrap=1 if bin_out=0.
  - d>=2: err=1; err_sticky=1; err_count+1 unless already at 2^CW-1.
  - Every case with d>=1 (including errors) loads prev_gray=gray_in and bin_out=conv(gray_in). The block resynchronises to the new value and keeps tracking.
  - With N=2, a 1-bit change is always +1 or -1, so step_up and step_dn are never both 1.
- enable=0: no sampling and all pulses 0. bin_out, bin_valid, prev_gray and the counters hold. FSM unchanged.
- Pulses last exactly one cycle per qualifying sample. Back-to-back enabled cycles produce back-to-back pulses.
- clr_err=1:
  - Clears err_count and err_sticky on the next edge.
  - If an error is detected on the same edge, the clear is applied first and then the increment, giving err_count=1 and err_sticky=1.
  - clr_err does not affect bin_out, bin_valid or the FSM.
- Reset asserted mid-stream: returns immediately to the reset state. The next enabled sample is treated as the first sample (EMPTY path), with no err or step pulses.

Test Plan:
- Reset low, then high; enable=0, gray_in=0101 (N=4) -> bin_valid stays 0, bin_out=0, no pulses.
- Up-count: enable=1, gray_in 0000,0001,0011,0010,0110 -> bin_out 0,1,2,3,4. bin_valid=1 after the 1st edge; step_up pulses on samples 2-5; err=0 throughout.
- Wrap and down-count:
  - gray_in 1001 then 1000 then 0000 -> bin_out 14,15,0. step_up=1 and wrap=1 on the 0000 sample.
  - Then 1000 -> bin_out 15, step_dn=1, wrap=1.
- Error and resync: from gray 0000 (bin 0) apply 0011 -> err=1, err_sticky=1, err_count=1, bin_out=2. Then 0010 -> step_up=1, err=0.
- Saturation/clear with CW=2:
  - Five consecutive 2-bit jumps -> err_count 1,2,3,3,3.
  - clr_err=1 alone -> err_count=0, err_sticky=0.
  - clr_err=1 with a simultaneous error -> err_count=1.
- Hold and async reset:
  - Repeat the same gray_in with enable=1 -> no pulses, bin_out stable.
  - Toggle enable off/on -> outputs hold while enable=0.
  - Assert reset mid-count -> all outputs 0 before the next edge. The first sample after release (e.g. 0110) gives bin_out=4 with no pulses.
